// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the elastic stage registers between MIPS pipeline stages.
//   slotState_e : occupancy of an elastic stage register, encoded as {skid valid, main valid}
//   IFID_W      : IF/ID payload width
//   IDEX_W      : ID/EX payload width
//   EXMEM_W     : EX/MEM payload width
package cpu_pipe_pkg;

   // The value 2'b10 (skid full while main is empty) cannot be reached.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } slotState_e;

   // pc_4(32) + instr(32)
   localparam int IFID_W  = 64;
   // pc_4(32) + rsData(32) + rtData(32) + imm(32) + rt(5) + rd(5) + control(9)
   localparam int IDEX_W  = 147;
   // branchTarget(32) + zero(1) + aluResult(32) + rtData(32) + destReg(5) + control(5)
   localparam int EXMEM_W = 107;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of an elastic stage register: a valid bit plus a payload.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture loadData and mark the entry valid
//   clear     : mark the entry invalid (wins over load for the valid bit)
//   loadData  : payload to capture
//   valid     : entry holds a payload
//   data      : stored payload (unchanged by clear)
module pipe_slot #(
   parameter int             W          = 64,
   parameter logic [W-1:0]   RESET_DATA = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          clear,
   input  logic [W-1:0]  loadData,
   output logic          valid,
   output logic [W-1:0]  data
);

   // NOTE: the payload register is reset as well as the valid bit, so out_data
   // is a known constant after reset instead of X propagating downstream.
   // NOTE: sequential state is assigned with <= so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= RESET_DATA;
      end else begin
         if (clear)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         // Payload only moves on a load, so X on an idle input never enters.
         if (load)
            data <= loadData;
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: a 2-entry skid buffer with valid/ready handshake,
// synchronous flush and a saturating stall-cycle counter.
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : squash all held entries (branch redirect)
//   in_valid/in_ready    : upstream handshake; in_ready is a pure register output
//   in_data              : upstream payload
//   out_valid/out_ready  : downstream handshake
//   out_data             : downstream payload, always from the main entry
//   stall_cnt            : cycles with out_valid=1 and out_ready=0, saturating
module pipe_stage_elastic
   import cpu_pipe_pkg::*;
#(
   parameter int                  DATA_W     = IFID_W,
   parameter int                  CNT_W      = 16,
   parameter logic [DATA_W-1:0]   RESET_DATA = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [CNT_W-1:0]   stall_cnt
);

   logic              mainV, skidV;
   logic [DATA_W-1:0] mainD, skidD, mainSrc;
   logic              inXfer, outXfer;
   logic              mainLoad, mainClear, skidLoad, skidClear;
   slotState_e        state;

   assign state     = slotState_e'({skidV, mainV});
   assign in_ready  = ~skidV;
   assign out_valid = mainV;
   assign out_data  = mainD;
   assign inXfer    = in_valid & in_ready;
   assign outXfer   = mainV & out_ready;

   // Main refills from the skid entry when draining FULL, else from upstream;
   // the skid entry is never bypassed, keeping strict FIFO order.
   assign mainSrc = (state == FULL) ? skidD : in_data;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      mainLoad  = 1'b0;
      skidLoad  = 1'b0;
      mainClear = flush;
      skidClear = flush;
      // Flush empties the stage and drops any incoming transfer; data is left as is.
      if (!flush) begin
         case (state)
            EMPTY: mainLoad = inXfer;
            ONE: begin
               mainLoad  = inXfer & outXfer;
               skidLoad  = inXfer & ~outXfer;
               mainClear = outXfer & ~inXfer;
            end
            FULL: begin
               mainLoad  = outXfer;
               skidClear = outXfer;
            end
            default: ;
         endcase
      end
   end

   pipe_slot #(.W(DATA_W), .RESET_DATA(RESET_DATA)) mainSlot (
      .clk      (clk),
      .rst      (rst),
      .load     (mainLoad),
      .clear    (mainClear),
      .loadData (mainSrc),
      .valid    (mainV),
      .data     (mainD)
   );

   pipe_slot #(.W(DATA_W), .RESET_DATA(RESET_DATA)) skidSlot (
      .clk      (clk),
      .rst      (rst),
      .load     (skidLoad),
      .clear    (skidClear),
      .loadData (in_data),
      .valid    (skidV),
      .data     (skidD)
   );

   // Counts regardless of flush; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (mainV && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;
   localparam int              DW    = 16;
   localparam int              CW    = 4;
   localparam logic [DW-1:0]   RST_D = 16'h00A5;
   localparam int              CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] stall_cnt;

   pipe_stage_elastic #(.DATA_W(DW), .CNT_W(CW), .RESET_DATA(RST_D)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a FIFO of at most two payloads plus a saturating counter.
   logic [DW-1:0] mq[$];
   int            mCnt = 0;
   logic [DW-1:0] consumed[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      mCnt = 0;
   endtask

   // Applies one rising edge to the model using the inputs held across it.
   task automatic modelEdge();
      bit popIt, pushIt;
      popIt  = (mq.size() > 0) && out_ready;
      pushIt = in_valid && (mq.size() < 2);
      if ((mq.size() > 0) && !out_ready && (mCnt < CMAX)) mCnt++;
      if (popIt) begin
         consumed.push_back(mq[0]);
         void'(mq.pop_front());
      end
      if (flush) mq.delete();
      else if (pushIt) mq.push_back(in_data);
   endtask

   task automatic compareAll();
      check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
      check("stall_cnt", 32'(stall_cnt), 32'(mCnt));
      if (mq.size() > 0) check("out_data", 32'(out_data), 32'(mq[0]));
   endtask

   task automatic step();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      compareAll();
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      modelReset();
      #12;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset out_data", 32'(out_data), 32'(RST_D));
      check("reset stall_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Streaming at full throughput.
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, DW'(i), 1'b1, 1'b0);
         step();
         check("stream data", 32'(out_data), 32'(i));
         check("stream in_ready", {31'd0, in_ready}, 32'd1);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
      check("stream drained", {31'd0, out_valid}, 32'd0);
      check("stream stall_cnt", 32'(stall_cnt), 32'd0);

      // Backpressure fills the skid entry, then drains in order.
      drive(1'b1, 16'h000A, 1'b1, 1'b0); step();
      drive(1'b1, 16'h000B, 1'b0, 1'b0); step();
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
      check("bp hold A", 32'(out_data), 32'h000A);
      check("bp stall 1", 32'(stall_cnt), 32'd1);
      drive(1'b0, '0, 1'b0, 1'b0); step(); step();
      check("bp stall 3", 32'(stall_cnt), 32'd3);
      check("bp still A", 32'(out_data), 32'h000A);
      drive(1'b0, '0, 1'b1, 1'b0); step();
      check("bp then B", 32'(out_data), 32'h000B);
      step();
      check("bp drained", {31'd0, out_valid}, 32'd0);

      // Flush while FULL drops the incoming 0xC and leaves data untouched.
      drive(1'b1, 16'h000A, 1'b1, 1'b0); step();
      drive(1'b1, 16'h000B, 1'b0, 1'b0); step();
      drive(1'b1, 16'h000C, 1'b0, 1'b1); step();
      check("flush out_valid", {31'd0, out_valid}, 32'd0);
      check("flush in_ready", {31'd0, in_ready}, 32'd1);
      check("flush stall counts", 32'(stall_cnt), 32'd5);
      check("flush keeps data", 32'(out_data), 32'h000A);
      drive(1'b0, '0, 1'b1, 1'b0); step(); step();
      check("flush no C", {31'd0, out_valid}, 32'd0);

      // Flush coincident with a downstream transfer.
      drive(1'b1, 16'h0005, 1'b1, 1'b0); step();
      check("one holds 5", 32'(out_data), 32'h0005);
      drive(1'b0, '0, 1'b1, 1'b1); step();
      check("flush+xfer consumed", 32'(consumed[consumed.size()-1]), 32'h0005);
      check("flush+xfer empty", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset between edges while FULL and stalled.
      drive(1'b0, '0, 1'b0, 1'b0);
      rst = 1'b1; #1; rst = 1'b0;
      modelReset();
      drive(1'b1, 16'h0011, 1'b0, 1'b0); step();
      drive(1'b1, 16'h0022, 1'b0, 1'b0); step();
      drive(1'b0, '0, 1'b0, 1'b0); step(); step();
      check("pre-reset stall 3", 32'(stall_cnt), 32'd3);
      check("pre-reset full", {31'd0, in_ready}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("async out_valid", {31'd0, out_valid}, 32'd0);
      check("async stall_cnt", 32'(stall_cnt), 32'd0);
      check("async in_ready", {31'd0, in_ready}, 32'd1);
      modelReset();
      #1 rst = 1'b0;
      step();

      // Counter saturation.
      drive(1'b1, 16'h0007, 1'b0, 1'b0); step();
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (20) step();
      check("stall saturates", 32'(stall_cnt), 32'd15);
      drive(1'b0, '0, 1'b1, 1'b0); step();
      check("sat drained", {31'd0, out_valid}, 32'd0);

      // Randomized traffic.
      rst = 1'b1; #1; rst = 1'b0;
      modelReset();
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
               $urandom_range(0, 29) == 0);
         step();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
